// File: rtl/jac1_top.sv
// Jac1-8: minimal 8-bit accumulator CPU with a 16-word parameterised ROM,
// a 16x8 register file, Z/C flags and one instruction per clock.
module jac1_top #(
    parameter int                DataWidth = 8,
    parameter logic [16*8-1:0]   RomImage  = {{12{8'hF0}}, 8'hC1, 8'hB0, 8'h31, 8'h10}
) (
    input  logic                 clk,
    input  logic                 sys_res_n,
    output logic [DataWidth-1:0] reg_val
);

    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LDH, OP_ADDI, OP_SUBI, OP_ADD, OP_SUB, OP_AND,
        OP_OR,  OP_XOR, OP_LD,  OP_ST,   OP_JMP,  OP_JZ,  OP_JC,  OP_HLT
    } op_e;

    logic [3:0]           pc_q, pc_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic                 z_q, z_d;
    logic                 c_q, c_d;
    logic                 halt_q, halt_d;
    logic [DataWidth-1:0] regs_q [16];
    logic [DataWidth-1:0] regs_d [16];

    logic [7:0]           instr;
    op_e                  op;
    logic [3:0]           n;
    logic [DataWidth-1:0] imm;
    logic [DataWidth-1:0] rn;
    logic [DataWidth:0]   sum;
    logic                 acc_wr;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        instr  = RomImage[{pc_q, 3'b000} +: 8];
        op     = op_e'(instr[7:4]);
        n      = instr[3:0];
        imm    = {{(DataWidth-4){1'b0}}, n};
        rn     = regs_q[n];

        pc_d   = pc_q + 4'd1;
        acc_d  = acc_q;
        z_d    = z_q;
        c_d    = c_q;
        halt_d = halt_q;
        regs_d = regs_q;
        sum    = '0;
        acc_wr = 1'b0;

        if (halt_q) begin
            pc_d = pc_q;
        end else begin
            case (op)
                OP_NOP: ;
                OP_LDI: begin acc_d = imm;                       acc_wr = 1'b1; end
                OP_LDH: begin acc_d = {n, acc_q[3:0]};           acc_wr = 1'b1; end
                OP_ADDI, OP_ADD: begin
                    sum    = {1'b0, acc_q} + {1'b0, (op == OP_ADDI) ? imm : rn};
                    acc_d  = sum[DataWidth-1:0];
                    c_d    = sum[DataWidth];
                    acc_wr = 1'b1;
                end
                // The ninth bit of the widened difference is the borrow (ACC < operand).
                OP_SUBI, OP_SUB: begin
                    sum    = {1'b0, acc_q} - {1'b0, (op == OP_SUBI) ? imm : rn};
                    acc_d  = sum[DataWidth-1:0];
                    c_d    = sum[DataWidth];
                    acc_wr = 1'b1;
                end
                OP_AND: begin acc_d = acc_q & rn; acc_wr = 1'b1; end
                OP_OR:  begin acc_d = acc_q | rn; acc_wr = 1'b1; end
                OP_XOR: begin acc_d = acc_q ^ rn; acc_wr = 1'b1; end
                OP_LD:  begin acc_d = rn;         acc_wr = 1'b1; end
                OP_ST:  regs_d[n] = acc_q;
                OP_JMP: pc_d = n;
                OP_JZ:  if (z_q) pc_d = n;
                OP_JC:  if (c_q) pc_d = n;
                OP_HLT: begin halt_d = 1'b1; pc_d = pc_q; end
            endcase
        end

        if (acc_wr) z_d = (acc_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!sys_res_n) begin
            pc_q   <= '0;
            acc_q  <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            halt_q <= 1'b0;
            // NOTE: the register file is architecturally cleared by reset, so it is built from flops.
            regs_q <= '{default: '0};
        end else begin
            pc_q   <= pc_d;
            acc_q  <= acc_d;
            z_q    <= z_d;
            c_q    <= c_d;
            halt_q <= halt_d;
            regs_q <= regs_d;
        end
    end

    assign reg_val = acc_q;

endmodule

// File: tb/tb_jac1_top.sv
// Bench for jac1_top: four ROM images run side by side against an
// instruction-level model, plus table-driven and hand-written checks.
module tb_jac1_top;

    localparam logic [127:0] RomDef = {{12{8'hF0}}, 8'hC1, 8'hB0, 8'h31, 8'h10};
    localparam logic [127:0] RomA   = {{11{8'hF0}}, 8'h19, 8'hF0, 8'hD4, 8'h45, 8'h15};
    localparam logic [127:0] RomB   = {{11{8'hF0}}, 8'h2A, 8'h52, 8'h10, 8'hB2, 8'h13};
    localparam logic [127:0] RomC   = {8'hD0, 8'hB3, 8'h00, 8'h51, 8'h41, 8'hA3, 8'h80, 8'h71,
                                       8'h91, 8'h61, 8'hF0, 8'hE6, 8'h32, 8'hB1, 8'h2F, 8'h1F};

    typedef struct packed {
        logic [3:0]       pc;
        logic [7:0]       acc;
        logic             z;
        logic             c;
        logic             halt;
        logic [15:0][7:0] r;
    } cpu_t;

    typedef struct {
        int         inst;
        int         edge_n;
        logic [7:0] val;
        logic       use_flags;
        logic       c;
        logic       z;
    } vec_t;

    logic       clk;
    logic       res_n [4];
    logic [7:0] rv    [4];

    jac1_top #(.DataWidth(8), .RomImage(RomDef)) u_dut0 (.clk(clk), .sys_res_n(res_n[0]), .reg_val(rv[0]));
    jac1_top #(.DataWidth(8), .RomImage(RomA))   u_dut1 (.clk(clk), .sys_res_n(res_n[1]), .reg_val(rv[1]));
    jac1_top #(.DataWidth(8), .RomImage(RomB))   u_dut2 (.clk(clk), .sys_res_n(res_n[2]), .reg_val(rv[2]));
    jac1_top #(.DataWidth(8), .RomImage(RomC))   u_dut3 (.clk(clk), .sys_res_n(res_n[3]), .reg_val(rv[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] roms [4];
    cpu_t         m    [4];
    logic [9:0]   hist [4][1024];
    int           pass_cnt  = 0;
    int           total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Instruction-set model: integer arithmetic straight from the opcode table.
    function automatic cpu_t model_step(input cpu_t s, input logic [127:0] rom);
        cpu_t t;
        int   instr, op, n, a, r, res;
        bit   wr;
        t = s;
        if (s.halt) return s;
        instr = int'((rom >> (32'(s.pc) * 8)) & 128'hFF);
        op  = instr / 16;
        n   = instr % 16;
        a   = int'(s.acc);
        r   = int'(s.r[n]);
        t.pc = 4'((int'(s.pc) + 1) % 16);
        wr  = 1'b1;
        res = a;
        case (op)
            1:  res = n;
            2:  res = n * 16 + a % 16;
            3:  begin res = a + n; t.c = (res > 255); end
            4:  begin res = a - n; t.c = (a < n);     end
            5:  begin res = a + r; t.c = (res > 255); end
            6:  begin res = a - r; t.c = (a < r);     end
            7:  res = a & r;
            8:  res = a | r;
            9:  res = a ^ r;
            10: res = r;
            11: begin wr = 1'b0; t.r[n] = s.acc; end
            12: begin wr = 1'b0; t.pc = 4'(n); end
            13: begin wr = 1'b0; if (s.z) t.pc = 4'(n); end
            14: begin wr = 1'b0; if (s.c) t.pc = 4'(n); end
            15: begin wr = 1'b0; t.halt = 1'b1; t.pc = s.pc; end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            res   = (res + 256) % 256;
            t.acc = 8'(res);
            t.z   = (res == 0);
        end
        return t;
    endfunction

    function automatic cpu_t observe(input int i);
        cpu_t o;
        o = '0;
        o.acc = rv[i];
        case (i)
            0: begin o.pc = u_dut0.pc_q; o.z = u_dut0.z_q; o.c = u_dut0.c_q; o.halt = u_dut0.halt_q; end
            1: begin o.pc = u_dut1.pc_q; o.z = u_dut1.z_q; o.c = u_dut1.c_q; o.halt = u_dut1.halt_q; end
            2: begin o.pc = u_dut2.pc_q; o.z = u_dut2.z_q; o.c = u_dut2.c_q; o.halt = u_dut2.halt_q; end
            default: begin o.pc = u_dut3.pc_q; o.z = u_dut3.z_q; o.c = u_dut3.c_q; o.halt = u_dut3.halt_q; end
        endcase
        return o;
    endfunction

    // Advance every model by the reset value in force, clock once, compare all instances.
    task automatic tick();
        cpu_t o;
        for (int i = 0; i < 4; i++) m[i] = res_n[i] ? model_step(m[i], roms[i]) : cpu_t'('0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            o = observe(i);
            check($sformatf("d%0d reg_val", i), int'(o.acc),  int'(m[i].acc));
            check($sformatf("d%0d pc", i),      int'(o.pc),   int'(m[i].pc));
            check($sformatf("d%0d z", i),       int'(o.z),    int'(m[i].z));
            check($sformatf("d%0d c", i),       int'(o.c),    int'(m[i].c));
            check($sformatf("d%0d halt", i),    int'(o.halt), int'(m[i].halt));
        end
    endtask

    vec_t vecs [$];
    cpu_t o;

    initial begin
        roms[0] = RomDef; roms[1] = RomA; roms[2] = RomB; roms[3] = RomC;
        for (int i = 0; i < 4; i++) begin res_n[i] = 1'b0; m[i] = '0; end

        // Expected values derived by hand from the program listings.
        vecs.push_back('{0, 1,   8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 2,   8'h01, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 5,   8'h02, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 8,   8'h03, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 20,  8'h07, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 764, 8'hFF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 767, 8'h00, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{0, 770, 8'h01, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1, 1,   8'h05, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 2,   8'h00, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1, 3,   8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 4,   8'h09, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 700, 8'h09, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 1,   8'h03, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 3,   8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 4,   8'h03, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 5,   8'hA3, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{2, 700, 8'hA3, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{3, 2,   8'hFF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3, 4,   8'h01, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3, 6,   8'h02, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3, 7,   8'hFD, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3, 10,  8'h00, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{3, 12,  8'hFE, 1'b1, 1'b1, 1'b0});

        // Reset hold for two edges.
        tick();
        tick();
        check("reset reg_val", int'(rv[0]), 0);
        check("reset pc", int'(u_dut0.pc_q), 0);

        // Release all and record history for the table.
        #3;
        for (int i = 0; i < 4; i++) res_n[i] = 1'b1;
        for (int e = 1; e <= 780; e++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                o = observe(i);
                hist[i][e] = {o.c, o.z, o.acc};
            end
        end
        foreach (vecs[k]) begin
            check($sformatf("table d%0d edge %0d reg_val", vecs[k].inst, vecs[k].edge_n),
                  int'(hist[vecs[k].inst][vecs[k].edge_n][7:0]), int'(vecs[k].val));
            if (vecs[k].use_flags) begin
                check($sformatf("table d%0d edge %0d c", vecs[k].inst, vecs[k].edge_n),
                      int'(hist[vecs[k].inst][vecs[k].edge_n][9]), int'(vecs[k].c));
                check($sformatf("table d%0d edge %0d z", vecs[k].inst, vecs[k].edge_n),
                      int'(hist[vecs[k].inst][vecs[k].edge_n][8]), int'(vecs[k].z));
            end
        end

        // Reset mid-run on the default program at reg_val=0x07, then restart.
        res_n[0] = 1'b0;
        tick();
        res_n[0] = 1'b1;
        for (int e = 0; e < 20; e++) tick();
        check("midrun pre-reset reg_val", int'(rv[0]), 8'h07);
        res_n[0] = 1'b0;
        tick();
        check("midrun reset reg_val", int'(rv[0]), 0);
        check("midrun reset pc", int'(u_dut0.pc_q), 0);
        res_n[0] = 1'b1;
        tick();
        check("restart edge1 reg_val", int'(rv[0]), 0);
        tick();
        check("restart edge2 reg_val", int'(rv[0]), 1);

        // Reset must also clear the halted state.
        res_n[1] = 1'b0;
        tick();
        check("halt cleared by reset", int'(u_dut1.halt_q), 0);
        res_n[1] = 1'b1;
        tick();
        check("after halt reset reg_val", int'(rv[1]), 8'h05);

        // Random reset pulses on every instance, checked against the model each edge.
        for (int e = 0; e < 600; e++) begin
            for (int i = 0; i < 4; i++) res_n[i] = ($urandom_range(0, 24) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
